optim_scheduler: RTL and testbench
==================================

# optim_scheduler

Sequences the shared-optimizer phases of training (parameter `update` and `zero_grad`) across the trainable layers (emb, mix, dense) one layer at a time. The layers share a single optimizer/gradient-memory port, so they must not run concurrently. The block sits between the main-state decode and the layers. It replaces direct broadcast of `update`/`zero_grad` and direct AND-reduction of per-layer valids with a sequenced request/acknowledge handshake and one aggregate completion flag per phase.

## Interface
- `N_LAYER`, default 3: number of sequenced layers, 1..8. Layer 0 is served first.
- `TIMEOUT`, default 1023: watchdog limit in cycles per layer, 1..65535. Used only with `OPTIM_WATCHDOG_EN`.
- `clk`, in, 1: single clock. All logic is on its rising edge.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `update`, in, 1: level request for the update phase. High for the whole of `M_UPDATE`.
- `zero_grad`, in, 1: level request for the zero-grad phase. High for the whole of `M_S1`.
- `layer_valid_update`, in, `N_LAYER`: per-layer update done (level).
- `layer_valid_zero_grad`, in, `N_LAYER`: per-layer zero-grad done (level).
- `layer_update`, out, `N_LAYER`: one-hot-or-zero update request to the layers.
- `layer_zero_grad`, out, `N_LAYER`: one-hot-or-zero zero-grad request to the layers.
- `cur_layer`, out, max(1,clog2(`N_LAYER`)): index of the layer being served.
- `valid_update`, out, 1: all layers updated.
- `valid_zero_grad`, out, 1: all layers zeroed.
- `busy`, out, 1: state is not IDLE.
- `error`, out, 1: sticky watchdog flag.

## Operation
- State register: IDLE, REQ, GAP, DONE. The `op` register holds UPD or ZG and is latched when leaving IDLE.
- **IDLE**:
  - `update`=1 → REQ with op=UPD, `cur_layer`=0.
  - Else `zero_grad`=1 → REQ with op=ZG, `cur_layer`=0.
  - If both are high, `update` wins.
- **REQ**: drives bit `cur_layer` of the op's request vector; all other bits are 0.
  - Only `layer_valid_<op>[cur_layer]` is sampled. Valids of other layers are ignored.
  - On valid=1 with `cur_layer`<`N_LAYER`-1 → GAP.
  - On valid=1 with `cur_layer`=`N_LAYER`-1 → DONE.
- **GAP**: all requests are 0 for one cycle so the next layer sees a clean rising edge. Then `cur_layer`+1 → REQ.
- **DONE**: `valid_<op>`=1 and requests are 0. Stays in DONE while the op's level input is high. Returns to IDLE the cycle after the level drops.
- **Abort**: if the latched op's level input drops in REQ or GAP → IDLE next edge. Requests go to 0 and `cur_layer` resets to 0. No valid is asserted.
  - The other level input rising mid-phase is ignored until IDLE.
- Requests and valids are registered outputs; nothing is combinational from the inputs.
- `busy` = (state≠IDLE).
- Reset value of every output is 0, and state is IDLE. Reset mid-phase drops requests at the same edge.

## Timing
- Edge t samples `update`=1 in IDLE → `layer_update[0]`=1 after t.
- A layer whose valid rises one cycle after its request gets a per-layer cost of 3 cycles (REQ 2 + GAP 1). The last layer costs 2 cycles.
- With layers that acknowledge immediately (valid high in the first REQ cycle), a phase takes 2·`N_LAYER` cycles from request to `valid_<op>`.
- `valid_<op>` deasserts exactly 1 cycle after the level input falls.
- Back-to-back phases: `zero_grad` high while DONE/UPD is exiting → the next REQ starts the cycle after the return to IDLE.

## Configuration
- **`OPTIM_WATCHDOG_EN` defined**:
  - A 16-bit counter clears on each REQ entry and increments each REQ cycle.
  - When the counter reaches `TIMEOUT` with no valid, `error` is set and the block jumps to DONE. It asserts `valid_<op>` so main state cannot hang.
  - `error` clears on reset or on the next IDLE→REQ transition.
- **Not defined**: no counter; `error` is tied to 0; REQ waits indefinitely.

## Test plan
- **Update sweep**: `N_LAYER`=3, layers ack 1 cycle after request. `update`=1 → `layer_update` goes 001,000,010,000,100 with the specified gaps, then `valid_update`=1. Drop `update` → `valid_update`=0 one cycle later, `busy`=0.
- **Priority**: `update`=`zero_grad`=1 in the same cycle → op=UPD. `layer_zero_grad` stays 000 throughout.
- **Abort**: `zero_grad` falls while `cur_layer`=1 in REQ → next edge all requests 0, `cur_layer`=0, `valid_zero_grad` never 1.
- **Ignore foreign valid**: hold `layer_valid_update`=111 before start → each layer still gets a GAP-separated request. Completes in 6 cycles.
- **Watchdog** (macro on, `TIMEOUT`=16): layer 1 never acks → `error`=1 and `valid_update`=1 after 16 REQ cycles on layer 1. The next phase start clears `error`.
- **Reset**: `rst_n`=0 during REQ → all outputs 0 and IDLE at that edge. A fresh `update` restarts at layer 0.

Source files
------------

// File: rtl/optim_scheduler_if.sv
// optim_scheduler_if: phase-level and per-layer handshake bundle for the
// optimizer scheduler. The master side is the main-state decode plus the
// layers; the slave side is the scheduler itself.
interface optim_scheduler_if #(
  parameter int unsigned N_LAYER = 3
);
  localparam int unsigned CW = (N_LAYER > 1) ? $clog2(N_LAYER) : 1;

  logic               update;
  logic               zero_grad;
  logic [N_LAYER-1:0] layer_valid_update;
  logic [N_LAYER-1:0] layer_valid_zero_grad;
  logic [N_LAYER-1:0] layer_update;
  logic [N_LAYER-1:0] layer_zero_grad;
  logic [CW-1:0]      cur_layer;
  logic               valid_update;
  logic               valid_zero_grad;
  logic               busy;
  logic               error;

  modport master (
    output update, zero_grad, layer_valid_update, layer_valid_zero_grad,
    input  layer_update, layer_zero_grad, cur_layer,
           valid_update, valid_zero_grad, busy, error
  );

  modport slave (
    input  update, zero_grad, layer_valid_update, layer_valid_zero_grad,
    output layer_update, layer_zero_grad, cur_layer,
           valid_update, valid_zero_grad, busy, error
  );
endinterface

// File: rtl/optim_scheduler.sv
// optim_scheduler: serialises the update / zero_grad optimizer phases over
// N_LAYER layers that share one optimizer port. Each layer gets a one-hot
// request, the scheduler waits for that layer's valid, inserts a one-cycle
// gap so the next layer sees a clean rising request, and raises one
// aggregate valid per phase once the last layer is done.
// Optional feature macro: OPTIM_WATCHDOG_EN (per-layer timeout, sticky error).
module optim_scheduler #(
  parameter int unsigned N_LAYER = 3,
  parameter int unsigned TIMEOUT = 1023
) (
  input logic              clk,
  input logic              rst_n,
  optim_scheduler_if.slave bus
);

  localparam int unsigned    CW   = (N_LAYER > 1) ? $clog2(N_LAYER) : 1;
  localparam logic [CW-1:0]  LAST = CW'(N_LAYER - 1);

  if (N_LAYER == 0 || N_LAYER > 8) begin : g_bad_n_layer
    $error("optim_scheduler: N_LAYER must be in 1..8");
  end
  if (TIMEOUT == 0 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("optim_scheduler: TIMEOUT must be in 1..65535");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  typedef enum logic {
    OP_UPD = 1'b0,
    OP_ZG  = 1'b1
  } op_t;

  state_t             state_q, state_d;
  op_t                op_q, op_d;
  logic [CW-1:0]      cur_q, cur_d;
  logic [N_LAYER-1:0] lu_q, lu_d;
  logic [N_LAYER-1:0] lz_q, lz_d;
  logic               vu_q, vu_d;
  logic               vz_q, vz_d;

  logic               op_level;
  logic               op_valid;

`ifdef OPTIM_WATCHDOG_EN
  logic [15:0]        cnt_q, cnt_d;
  logic               err_q, err_d;
`endif

  // Select the level input and the current layer's valid for the latched op.
  always_comb begin
    op_level = (op_q == OP_UPD) ? bus.update : bus.zero_grad;
    op_valid = 1'b0;
    for (int unsigned i = 0; i < N_LAYER; i++) begin
      if (cur_q == CW'(i)) begin
        op_valid = (op_q == OP_UPD) ? bus.layer_valid_update[i]
                                    : bus.layer_valid_zero_grad[i];
      end
    end
  end

  // Next-state logic: phase start, per-layer handshake, gap, completion, abort.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cur_d   = cur_q;
`ifdef OPTIM_WATCHDOG_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        cur_d = '0;
        if (bus.update || bus.zero_grad) begin
          state_d = S_REQ;
          op_d    = bus.update ? OP_UPD : OP_ZG;
`ifdef OPTIM_WATCHDOG_EN
          cnt_d   = '0;
          err_d   = 1'b0;
`endif
        end
      end
      S_REQ: begin
        if (!op_level) begin
          state_d = S_IDLE;
          cur_d   = '0;
        end else if (op_valid) begin
          state_d = (cur_q == LAST) ? S_DONE : S_GAP;
        end else begin
`ifdef OPTIM_WATCHDOG_EN
          if (({1'b0, cnt_q} + 17'd1) >= 17'(TIMEOUT)) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
`endif
        end
      end
      S_GAP: begin
        if (!op_level) begin
          state_d = S_IDLE;
          cur_d   = '0;
        end else begin
          state_d = S_REQ;
          cur_d   = cur_q + CW'(1);
`ifdef OPTIM_WATCHDOG_EN
          cnt_d   = '0;
`endif
        end
      end
      S_DONE: begin
        if (!op_level) begin
          state_d = S_IDLE;
          cur_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cur_d   = '0;
      end
    endcase
  end

  // Registered outputs are decoded from the next state so they change on the
  // same edge as the state they describe.
  always_comb begin
    lu_d = '0;
    lz_d = '0;
    if (state_d == S_REQ) begin
      for (int unsigned i = 0; i < N_LAYER; i++) begin
        if (cur_d == CW'(i)) begin
          if (op_d == OP_UPD) lu_d[i] = 1'b1;
          else                lz_d[i] = 1'b1;
        end
      end
    end
    vu_d = (state_d == S_DONE) && (op_d == OP_UPD);
    vz_d = (state_d == S_DONE) && (op_d == OP_ZG);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_UPD;
      cur_q   <= '0;
      lu_q    <= '0;
      lz_q    <= '0;
      vu_q    <= 1'b0;
      vz_q    <= 1'b0;
`ifdef OPTIM_WATCHDOG_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cur_q   <= cur_d;
      lu_q    <= lu_d;
      lz_q    <= lz_d;
      vu_q    <= vu_d;
      vz_q    <= vz_d;
`ifdef OPTIM_WATCHDOG_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign bus.layer_update    = lu_q;
  assign bus.layer_zero_grad = lz_q;
  assign bus.cur_layer       = cur_q;
  assign bus.valid_update    = vu_q;
  assign bus.valid_zero_grad = vz_q;
  assign bus.busy            = (state_q != S_IDLE);
`ifdef OPTIM_WATCHDOG_EN
  assign bus.error           = err_q;
`else
  assign bus.error           = 1'b0;
`endif

endmodule

// File: tb/tb_optim_scheduler.sv
// tb_optim_scheduler: directed bench for optim_scheduler with N_LAYER=3 and
// TIMEOUT=16. Layers are either driven manually or by a responder that
// raises each layer's valid one cycle after its request.
module tb_optim_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  optim_scheduler_if #(.N_LAYER(3)) bus ();

  optim_scheduler #(.N_LAYER(3), .TIMEOUT(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic       auto_en = 1'b0;
  logic [2:0] auto_vu = '0;
  logic [2:0] auto_vz = '0;
  logic [2:0] man_vu  = '0;
  logic [2:0] man_vz  = '0;

  // Layer responder: valid follows request with one cycle of latency.
  always @(posedge clk) begin
    auto_vu <= bus.layer_update;
    auto_vz <= bus.layer_zero_grad;
  end

  assign bus.layer_valid_update    = auto_en ? auto_vu : man_vu;
  assign bus.layer_valid_zero_grad = auto_en ? auto_vz : man_vz;

  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.update = 1'b0;
    bus.zero_grad = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({bus.layer_update, bus.layer_zero_grad, bus.cur_layer, bus.valid_update,
         bus.valid_zero_grad, bus.busy, bus.error} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs got lu=%b lz=%b cur=%0d vu=%b vz=%b busy=%b err=%b want all 0",
               bus.layer_update, bus.layer_zero_grad, bus.cur_layer, bus.valid_update,
               bus.valid_zero_grad, bus.busy, bus.error);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle busy got %b want 0", bus.busy);
    end
  endtask

  task automatic test_update_sweep();
    logic [2:0] exp_lu [9];
    logic [1:0] exp_cur [9];
    exp_lu  = '{3'b001, 3'b001, 3'b000, 3'b010, 3'b010, 3'b000, 3'b100, 3'b100, 3'b000};
    exp_cur = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2};
    auto_en = 1'b1;
    bus.update = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      checks++;
      if (bus.layer_update !== exp_lu[i] || bus.cur_layer !== exp_cur[i] ||
          bus.valid_update !== (i == 8) || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL sweep cyc %0d got lu=%b cur=%0d vu=%b busy=%b want lu=%b cur=%0d vu=%b busy=1",
                 i, bus.layer_update, bus.cur_layer, bus.valid_update, bus.busy,
                 exp_lu[i], exp_cur[i], (i == 8));
      end
    end
    tick();
    checks++;
    if (bus.valid_update !== 1'b1 || bus.layer_update !== 3'b000) begin
      errors++;
      $display("FAIL sweep_hold got vu=%b lu=%b want vu=1 lu=000", bus.valid_update, bus.layer_update);
    end
    bus.update = 1'b0;
    tick();
    checks++;
    if (bus.valid_update !== 1'b0 || bus.busy !== 1'b0 || bus.cur_layer !== 2'd0) begin
      errors++;
      $display("FAIL sweep_exit got vu=%b busy=%b cur=%0d want vu=0 busy=0 cur=0",
               bus.valid_update, bus.busy, bus.cur_layer);
    end
  endtask

  task automatic test_priority_back_to_back();
    logic [2:0] exp_req [9];
    exp_req = '{3'b001, 3'b001, 3'b000, 3'b010, 3'b010, 3'b000, 3'b100, 3'b100, 3'b000};
    auto_en = 1'b1;
    bus.update = 1'b1;
    bus.zero_grad = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      checks++;
      if (bus.layer_update !== exp_req[i] || bus.layer_zero_grad !== 3'b000 ||
          bus.valid_update !== (i == 8) || bus.valid_zero_grad !== 1'b0) begin
        errors++;
        $display("FAIL priority cyc %0d got lu=%b lz=%b vu=%b vz=%b want lu=%b lz=000 vu=%b vz=0",
                 i, bus.layer_update, bus.layer_zero_grad, bus.valid_update,
                 bus.valid_zero_grad, exp_req[i], (i == 8));
      end
    end
    bus.update = 1'b0;
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.valid_update !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle got busy=%b vu=%b want busy=0 vu=0", bus.busy, bus.valid_update);
    end
    for (int i = 0; i < 9; i++) begin
      tick();
      checks++;
      if (bus.layer_zero_grad !== exp_req[i] || bus.layer_update !== 3'b000 ||
          bus.valid_zero_grad !== (i == 8)) begin
        errors++;
        $display("FAIL b2b_zg cyc %0d got lz=%b lu=%b vz=%b want lz=%b lu=000 vz=%b",
                 i, bus.layer_zero_grad, bus.layer_update, bus.valid_zero_grad,
                 exp_req[i], (i == 8));
      end
    end
    bus.zero_grad = 1'b0;
    tick();
    checks++;
    if (bus.valid_zero_grad !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_exit got vz=%b busy=%b want 0 0", bus.valid_zero_grad, bus.busy);
    end
  endtask

  task automatic test_abort();
    auto_en = 1'b1;
    bus.zero_grad = 1'b1;
    repeat (4) tick();
    checks++;
    if (bus.layer_zero_grad !== 3'b010 || bus.cur_layer !== 2'd1) begin
      errors++;
      $display("FAIL abort_pre got lz=%b cur=%0d want lz=010 cur=1", bus.layer_zero_grad, bus.cur_layer);
    end
    bus.zero_grad = 1'b0;
    tick();
    checks++;
    if (bus.layer_zero_grad !== 3'b000 || bus.layer_update !== 3'b000 ||
        bus.cur_layer !== 2'd0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL abort got lz=%b lu=%b cur=%0d busy=%b want 000 000 0 0",
               bus.layer_zero_grad, bus.layer_update, bus.cur_layer, bus.busy);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.valid_zero_grad !== 1'b0) begin
        errors++;
        $display("FAIL abort_valid cyc %0d got vz=%b want 0", i, bus.valid_zero_grad);
      end
    end
  endtask

  task automatic test_foreign_valid();
    logic [2:0] exp_lu [6];
    exp_lu = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000};
    auto_en = 1'b0;
    man_vu = 3'b111;
    tick();
    bus.update = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (bus.layer_update !== exp_lu[i] || bus.valid_update !== (i == 5)) begin
        errors++;
        $display("FAIL foreign cyc %0d got lu=%b vu=%b want lu=%b vu=%b",
                 i, bus.layer_update, bus.valid_update, exp_lu[i], (i == 5));
      end
    end
    bus.update = 1'b0;
    man_vu = 3'b000;
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL foreign_exit got busy=%b want 0", bus.busy);
    end
  endtask

  task automatic test_watchdog();
    auto_en = 1'b0;
    man_vu = 3'b001;
    bus.update = 1'b1;
    repeat (3) tick();
    checks++;
    if (bus.layer_update !== 3'b010 || bus.cur_layer !== 2'd1) begin
      errors++;
      $display("FAIL wd_layer1 got lu=%b cur=%0d want lu=010 cur=1", bus.layer_update, bus.cur_layer);
    end
    repeat (15) tick();
    checks++;
    if (bus.layer_update !== 3'b010 || bus.error !== 1'b0 || bus.valid_update !== 1'b0) begin
      errors++;
      $display("FAIL wd_before got lu=%b err=%b vu=%b want lu=010 err=0 vu=0",
               bus.layer_update, bus.error, bus.valid_update);
    end
    tick();
`ifdef OPTIM_WATCHDOG_EN
    checks++;
    if (bus.error !== 1'b1 || bus.valid_update !== 1'b1 || bus.layer_update !== 3'b000) begin
      errors++;
      $display("FAIL wd_fire got err=%b vu=%b lu=%b want err=1 vu=1 lu=000",
               bus.error, bus.valid_update, bus.layer_update);
    end
`else
    checks++;
    if (bus.error !== 1'b0 || bus.valid_update !== 1'b0 || bus.layer_update !== 3'b010) begin
      errors++;
      $display("FAIL wd_wait got err=%b vu=%b lu=%b want err=0 vu=0 lu=010",
               bus.error, bus.valid_update, bus.layer_update);
    end
`endif
    bus.update = 1'b0;
    man_vu = 3'b000;
    tick();
    checks++;
`ifdef OPTIM_WATCHDOG_EN
    if (bus.busy !== 1'b0 || bus.error !== 1'b1) begin
      errors++;
      $display("FAIL wd_sticky got busy=%b err=%b want busy=0 err=1", bus.busy, bus.error);
    end
`else
    if (bus.busy !== 1'b0 || bus.error !== 1'b0) begin
      errors++;
      $display("FAIL wd_idle got busy=%b err=%b want busy=0 err=0", bus.busy, bus.error);
    end
`endif
    man_vz = 3'b111;
    bus.zero_grad = 1'b1;
    tick();
    checks++;
    if (bus.error !== 1'b0 || bus.layer_zero_grad !== 3'b001) begin
      errors++;
      $display("FAIL wd_clear got err=%b lz=%b want err=0 lz=001", bus.error, bus.layer_zero_grad);
    end
    repeat (5) tick();
    checks++;
    if (bus.valid_zero_grad !== 1'b1 || bus.error !== 1'b0) begin
      errors++;
      $display("FAIL wd_zg_done got vz=%b err=%b want vz=1 err=0", bus.valid_zero_grad, bus.error);
    end
    bus.zero_grad = 1'b0;
    man_vz = 3'b000;
    tick();
  endtask

  task automatic test_mid_reset();
    auto_en = 1'b1;
    bus.update = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({bus.layer_update, bus.layer_zero_grad, bus.cur_layer, bus.valid_update,
         bus.valid_zero_grad, bus.busy, bus.error} !== 13'd0) begin
      errors++;
      $display("FAIL mid_reset got lu=%b lz=%b cur=%0d vu=%b vz=%b busy=%b err=%b want all 0",
               bus.layer_update, bus.layer_zero_grad, bus.cur_layer, bus.valid_update,
               bus.valid_zero_grad, bus.busy, bus.error);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.layer_update !== 3'b001 || bus.cur_layer !== 2'd0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL restart got lu=%b cur=%0d busy=%b want lu=001 cur=0 busy=1",
               bus.layer_update, bus.cur_layer, bus.busy);
    end
    bus.update = 1'b0;
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.layer_update !== 3'b000) begin
      errors++;
      $display("FAIL restart_abort got busy=%b lu=%b want busy=0 lu=000", bus.busy, bus.layer_update);
    end
  endtask

  initial begin
    bus.update = 1'b0;
    bus.zero_grad = 1'b0;
    test_reset();
    test_update_sweep();
    test_priority_back_to_back();
    test_abort();
    test_foreign_valid();
    test_watchdog();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
